// File: rtl/linebuffer_window9.sv
// linebuffer_window9: 9x9 sliding pixel window over a raster stream, built from 8 row line buffers.
// Optional macro LB_SOF_SYNC_EN adds a sof input that re-aligns the frame counters to (0,0).
module linebuffer_window9 #(
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] pix_in,
   input  logic       pix_valid,
`ifdef LB_SOF_SYNC_EN
   input  logic       sof,
`endif
   output logic [6:0] xarray [0:80],
   output logic       win_valid
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(8);
   localparam logic [RW-1:0] ROW_MIN  = RW'(8);

   logic [CW-1:0] col_q, col_d, wr_col_s;
   logic [RW-1:0] row_q, row_d;
   logic          shift_s, lb_we_s, win_valid_d, sof_s;
   logic [6:0]    lb_q  [0:7][0:IMG_WIDTH-1];
   logic [6:0]    tap_s [0:8];

`ifdef LB_SOF_SYNC_EN
   assign sof_s = sof;
`else
   assign sof_s = 1'b0;
`endif

   // Next-state for raster counters, window shift enable and window strobe
   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      wr_col_s    = col_q;
      shift_s     = 1'b0;
      lb_we_s     = 1'b0;
      win_valid_d = 1'b0;
      if (sof_s) begin
         // sof re-aligns: the pixel (if any) lands at (0,0) but never enters the window
         row_d    = {RW{1'b0}};
         wr_col_s = {CW{1'b0}};
         if (pix_valid) begin
            col_d   = CW'(1);
            lb_we_s = 1'b1;
         end else begin
            col_d   = {CW{1'b0}};
         end
      end else if (pix_valid) begin
         shift_s     = 1'b1;
         lb_we_s     = 1'b1;
         win_valid_d = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
         if (col_q == COL_LAST) begin
            col_d = {CW{1'b0}};
            if (row_q == ROW_LAST) begin
               row_d = {RW{1'b0}};
            end else begin
               row_d = row_q + RW'(1);
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end else begin
         shift_s = 1'b0;
      end
   end

   // Column taps: eight stored rows above the current pixel plus the pixel itself
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         tap_s[k] = lb_q[k][col_q];
      end
      tap_s[8] = pix_in;
   end

   // Line buffer cascade: each row moves up one buffer, the new pixel enters the bottom one
   always_ff @(posedge clk) begin
      if (lb_we_s && !rst) begin
         for (int k = 0; k < 7; k++) begin
            lb_q[k][wr_col_s] <= lb_q[k+1][wr_col_s];
         end
         lb_q[7][wr_col_s] <= pix_in;
      end
   end

   // Counters, window register and strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q     <= {CW{1'b0}};
         row_q     <= {RW{1'b0}};
         win_valid <= 1'b0;
         for (int i = 0; i < 81; i++) begin
            xarray[i] <= 7'd0;
         end
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         win_valid <= win_valid_d;
         if (shift_s) begin
            for (int k = 0; k < 9; k++) begin
               for (int c = 0; c < 8; c++) begin
                  xarray[k*9+c] <= xarray[k*9+c+1];
               end
               xarray[k*9+8] <= tap_s[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_linebuffer_window9.sv
// Self-checking bench for linebuffer_window9: a frame-image reference model predicts every window
// directly from stored pixels; stimulus is a linear sequence of directed phases with random data/gaps.
module tb_linebuffer_window9;

   localparam int W = 28;
   localparam int H = 28;
`ifdef LB_SOF_SYNC_EN
   localparam bit SOF_EN = 1'b1;
`else
   localparam bit SOF_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, pix_valid, sof;
   logic [6:0] pix_in;
   logic [6:0] xarray [0:80];
   logic       win_valid;

   always #5 clk = ~clk;

   linebuffer_window9 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk       (clk),
      .rst       (rst),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
`ifdef LB_SOF_SYNC_EN
      .sof       (sof),
`endif
      .xarray    (xarray),
      .win_valid (win_valid)
   );

   int checks = 0;
   int errors = 0;

   logic [6:0] img   [0:H-1][0:W-1];
   logic [6:0] exp_x [0:80];
   bit exp_known = 1'b0;
   bit exp_wv;
   bit frame_end;
   bit first_pending = 1'b0;
   bit const_check = 1'b0;
   int m_row = 0, m_col = 0, acc_since = 0, win_count = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step(input logic v, input logic [6:0] p, input logic r, input logic s);
      rst = r; pix_valid = v; pix_in = p; sof = s;
      @(posedge clk);
      exp_wv    = 1'b0;
      frame_end = 1'b0;
      if (r) begin
         m_row = 0; m_col = 0;
         for (int i = 0; i < 81; i++) exp_x[i] = 7'd0;
         exp_known = 1'b1;
         acc_since = 0; first_pending = 1'b1; win_count = 0;
      end else if (SOF_EN && s) begin
         m_row = 0; acc_since = 0; first_pending = 1'b1; win_count = 0;
         if (v) begin
            img[0][0] = p; m_col = 1; acc_since = 1;
         end else begin
            m_col = 0;
         end
      end else if (v) begin
         acc_since++;
         img[m_row][m_col] = p;
         if (m_row >= 8 && m_col >= 8) begin
            exp_wv = 1'b1;
            for (int rr = 0; rr < 9; rr++)
               for (int cc = 0; cc < 9; cc++)
                  exp_x[rr*9+cc] = img[m_row-8+rr][m_col-8+cc];
            exp_known = 1'b1;
         end else begin
            exp_known = 1'b0;
         end
         m_col++;
         if (m_col == W) begin
            m_col = 0; m_row++;
            if (m_row == H) begin
               m_row = 0; frame_end = 1'b1;
            end
         end
      end
      #1;
      check("win_valid", {31'd0, win_valid}, {31'd0, exp_wv});
      if (exp_known)
         for (int i = 0; i < 81; i++)
            check($sformatf("xarray[%0d]", i), {25'd0, xarray[i]}, {25'd0, exp_x[i]});
      if (win_valid === 1'b1) win_count++;
      if (first_pending && win_valid === 1'b1) begin
         check("first_win_latency", acc_since, 8*W + 9);
         if (const_check) begin
            check("first_win_x0",  {25'd0, xarray[0]},  32'd0);
            check("first_win_x8",  {25'd0, xarray[8]},  32'd8);
            check("first_win_x72", {25'd0, xarray[72]}, 32'd96);
            check("first_win_x80", {25'd0, xarray[80]}, 32'd104);
            const_check = 1'b0;
         end
         first_pending = 1'b0;
      end
      if (frame_end) begin
         check("frame_win_count", win_count, (W-8)*(H-8));
         win_count = 0;
      end
   endtask

   task automatic feed(input int n, input int gap_max, input bit rnd);
      int g;
      logic [6:0] p;
      for (int i = 0; i < n; i++) begin
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         for (int j = 0; j < g; j++) step(1'b0, 7'($urandom), 1'b0, 1'b0);
         p = rnd ? 7'($urandom) : 7'((m_row*W + m_col) % 128);
         step(1'b1, p, 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b1; pix_valid = 1'b0; pix_in = 7'd0; sof = 1'b0;
      // Reset held two cycles while a pixel is offered
      step(1'b1, 7'h55, 1'b1, 1'b0);
      step(1'b1, 7'h55, 1'b1, 1'b0);
      // Two continuous frames with index-pattern pixels
      const_check = 1'b1;
      feed(2*W*H, 0, 1'b0);
      // Same frame with random idle gaps
      feed(W*H, 5, 1'b0);
      // Mid-frame reset, then a full random-data frame with gaps
      feed(300, 0, 1'b1);
      step(1'b1, 7'h55, 1'b1, 1'b0);
      feed(W*H, 2, 1'b1);
      if (SOF_EN) begin
         feed(100, 0, 1'b1);
         step(1'b1, 7'($urandom), 1'b0, 1'b1);
         feed(W*H - 1, 1, 1'b1);
         feed(50, 0, 1'b1);
         step(1'b0, 7'd0, 1'b0, 1'b1);
         feed(W*H, 0, 1'b1);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 7'($urandom), 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/linebuffer_window9.md
LINEBUFFER_WINDOW9 -- requirements
Module: linebuffer_window9

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 28, meaning pixels per image row (legal range 9..1024).
REQ-002 SHALL have parameter IMG_HEIGHT, default 28, meaning rows per frame (legal range 9..1024).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port pix_in  input  7  raster-order pixel, sampled when pix_valid=1.
REQ-006 SHALL have port pix_valid  input  1  pixel accept strobe; no backpressure exists.
REQ-007 SHALL have port sof  input  1  start-of-frame; present only with LB_SOF_SYNC_EN (REQ-024).
REQ-008 SHALL have port xarray  output  7 x [0:80]  registered 9x9 window feeding innerproduct-style consumers.
REQ-009 SHALL have port win_valid  output  1  one-cycle strobe marking xarray as a complete in-image window.

Function
REQ-010 SHALL keep col counter 0..IMG_WIDTH-1 and row counter 0..IMG_HEIGHT-1, advanced only on accepted pixels (pix_valid=1).
REQ-011 SHALL wrap col at IMG_WIDTH-1 to 0 and increment row; at (IMG_HEIGHT-1, IMG_WIDTH-1), wrap both counters to 0 for the next frame.
REQ-012 SHALL store the previous 8 rows in 8 line buffers of IMG_WIDTH x 7 bits, indexed by col, written with the accepted pixel cascade (row shift) on each accept.
REQ-013 SHALL form a 9-tap column per accept: tap[8]=pix_in; tap[k]=pixel (row-8+k, col) for k=0..7.
REQ-014 SHALL, per accept, shift every window row one position toward lower index and load the new column: xarray[k*9+8]<=tap[k]; xarray[k*9+c]<=xarray[k*9+c+1] for c=0..7.
REQ-015 SHALL give xarray[r*9+c] = pixel (row-8+r, col-8+c) relative to the accepted pixel (row, col); xarray[0] is oldest/top-left, xarray[80] newest/bottom-right.
REQ-016 SHALL assert win_valid for exactly one cycle, in the cycle after accepting a pixel with row>=8 and col>=8; otherwise 0 (latency 1 clk).
REQ-017 SHALL produce exactly (IMG_WIDTH-8)*(IMG_HEIGHT-8) win_valid pulses per frame; no window spans a row wrap.
REQ-018 SHALL hold counters, line buffers and xarray unchanged, with win_valid=0, in cycles where pix_valid=0.
REQ-019 SHALL use unsigned 7-bit pixel arithmetic only; no value modification between pix_in and xarray.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, clear col and row to 0, xarray to all zeros, and win_valid to 0; rst overrides pix_valid and sof in the same cycle.
REQ-021 SHALL NOT require line buffer memory clearing on reset; stale contents are never exposed because win_valid requires row>=8 after reset.
REQ-022 SHALL, on reset mid-frame, treat the first accepted pixel after rst deassertion as (0,0).

Configuration
REQ-023 SHALL, without macro LB_SOF_SYNC_EN, omit the sof port; frame alignment relies solely on counter wrap (REQ-011).
REQ-024 SHALL, with LB_SOF_SYNC_EN defined, add the sof port: sof=1 with pix_valid=1 accepts pix_in as (0,0), with counters advancing to (0,1); sof=1 with pix_valid=0 clears counters so the next accept is (0,0); neither case changes xarray, and win_valid=0 in the following cycle.

Verification
REQ-025 SHALL verify reset: rst high 2 cycles with pix_valid=1, pix_in=7'h55 -> win_valid=0, all 81 xarray entries 0.
REQ-026 SHALL verify the first window: default 28x28 frame, pix_in=(row*28+col) mod 128, pix_valid=1 continuously -> first win_valid the cycle after pixel index 232, with xarray[0]=0, xarray[8]=8, xarray[72]=96, xarray[80]=104.
REQ-027 SHALL verify the window count: full 28x28 frame -> exactly 400 win_valid pulses, none after pixels with col<8 or row<8; the second frame repeats the same sequence.
REQ-028 SHALL verify stalls: same frame with random pix_valid gaps (up to 5 idle cycles) -> identical xarray sequence at each win_valid pulse, and win_valid=0 on idle cycles.
REQ-029 SHALL verify mid-frame reset: rst asserted after pixel index 300 -> win_valid=0 and xarray=0 next cycle; the next win_valid occurs only after 233 further accepted pixels.
REQ-030 SHALL verify, with LB_SOF_SYNC_EN: sof with pix_valid after 100 pixels -> that pixel is (0,0); the first subsequent win_valid occurs after that pixel plus 232 more accepts.
